// File: rtl/csum_pkg.sv
// csum_pkg: shared definitions for the pipelined conditional-sum adder.
//   csum_levels()      - number of datapath levels for an operand width
//                        (one pair-forming level plus log2(width) merge levels)
//   csum_level_stage() - which register stage a given level lives in
//   csum_result_t      - result record {sum, cout, ovf, zero}, sum sized for
//                        the widest supported operand
package csum_pkg;

   localparam int MAX_WIDTH = 64;

   function automatic int csum_levels(input int width);
      return $clog2(width) + 1;
   endfunction

   // Levels are dealt out to stages as evenly as possible; when they do not
   // divide evenly the first (levels % stages) stages get one extra level.
   function automatic int csum_level_stage(input int level, input int levels,
                                           input int stages);
      int base;
      int rem;
      int acc;
      int st;
      if (stages < 1) return 0;
      base = levels / stages;
      rem  = levels % stages;
      acc  = 0;
      st   = 0;
      for (int s = 0; s < stages; s++) begin
         if (level >= acc) st = s;
         acc += base + ((s < rem) ? 1 : 0);
      end
      return st;
   endfunction

   typedef struct packed {
      logic [MAX_WIDTH-1:0] sum;
      logic                 cout;
      logic                 ovf;
      logic                 zero;
   } csum_result_t;

endpackage

// File: rtl/csum_merge.sv
// csum_merge: one merge level of the conditional-sum adder.
//   Inputs are blocks of width BLK/2, each carrying a sum/carry pair for an
//   assumed carry-in of 0 (s0/c0) and of 1 (s1/c1). Adjacent blocks are
//   merged into blocks of width BLK: the lower half passes through, the upper
//   half is picked by the lower half's carry for the same assumption.
//   i_s0/i_s1 : WIDTH-bit sums, carry-in 0 / 1
//   i_c0/i_c1 : one carry per input block (2*WIDTH/BLK bits)
//   o_s0/o_s1 : WIDTH-bit merged sums
//   o_c0/o_c1 : one carry per output block (WIDTH/BLK bits)
module csum_merge #(
   parameter int WIDTH = 32,
   parameter int BLK   = 2
) (
   input  logic [WIDTH-1:0]         i_s0,
   input  logic [WIDTH-1:0]         i_s1,
   input  logic [2*WIDTH/BLK-1:0]   i_c0,
   input  logic [2*WIDTH/BLK-1:0]   i_c1,
   output logic [WIDTH-1:0]         o_s0,
   output logic [WIDTH-1:0]         o_s1,
   output logic [WIDTH/BLK-1:0]     o_c0,
   output logic [WIDTH/BLK-1:0]     o_c1
);

   localparam int H  = BLK / 2;
   localparam int NB = WIDTH / BLK;

   for (genvar k = 0; k < NB; k++) begin : g_pair
      assign o_s0[k*BLK +: H]   = i_s0[k*BLK +: H];
      assign o_s1[k*BLK +: H]   = i_s1[k*BLK +: H];
      assign o_s0[k*BLK+H +: H] = i_c0[2*k] ? i_s1[k*BLK+H +: H] : i_s0[k*BLK+H +: H];
      assign o_s1[k*BLK+H +: H] = i_c1[2*k] ? i_s1[k*BLK+H +: H] : i_s0[k*BLK+H +: H];
      assign o_c0[k] = i_c0[2*k] ? i_c1[2*k+1] : i_c0[2*k+1];
      assign o_c1[k] = i_c1[2*k] ? i_c1[2*k+1] : i_c0[2*k+1];
   end

endmodule

// File: rtl/pipelined_csum_adder.sv
// pipelined_csum_adder: valid/ready pipelined conditional-sum adder/subtractor.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = pipeline advances)
//   a, b, cin, op_sub   : operands; op_sub=1 computes a - b and ignores cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf, zero: registered result; cout=1 means no borrow in subtract
// Datapath: level 0 forms per-bit sum/carry pairs, log2(WIDTH) merge levels
// double the block width, the final carry-in select sits after the last merge.
// Levels are split across STAGES register stages; the last stage register is
// the output register. All stages move together whenever the output is free.
module pipelined_csum_adder
   import csum_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int LEVELS = csum_levels(WIDTH);

   if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_csum_adder: WIDTH must be a power of two in 8..64");
   end
   if (STAGES < 1 || STAGES > LEVELS) begin : g_bad_stages
      $error("pipelined_csum_adder: STAGES must be in 1..log2(WIDTH)+1");
   end

   logic               w_adv;
   logic [STAGES-1:0]  r_vld;
   csum_result_t       r_res;
   csum_result_t       w_res;
   logic [WIDTH-1:0]   w_beff;
   logic [WIDTH-1:0]   w_fsum;
   logic               w_fcout;
   logic [2:0]         w_fsb;
   logic               w_unused_res;

   assign w_adv    = !r_vld[STAGES-1] || out_ready;
   assign in_ready = w_adv;
   assign w_beff   = op_sub ? ~b : b;

   // Each level carries sideband {a msb, effective-b msb, effective carry-in}
   // so overflow and the final select can be resolved after the last merge.
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int NB   = WIDTH >> l;
      localparam bit LAST = (l == LEVELS - 1);
      localparam bit BND  = LAST ||
         (csum_level_stage(l + 1, LEVELS, STAGES) != csum_level_stage(l, LEVELS, STAGES));

      logic [WIDTH-1:0] w_s0, w_s1, w_q_s0, w_q_s1;
      logic [NB-1:0]    w_c0, w_c1, w_q_c0, w_q_c1;
      logic [2:0]       w_sb, w_q_sb;

      if (l == 0) begin : g_form
         assign w_s0 = a ^ w_beff;
         assign w_s1 = ~(a ^ w_beff);
         assign w_c0 = a & w_beff;
         assign w_c1 = a | w_beff;
         assign w_sb = {a[WIDTH-1], w_beff[WIDTH-1], op_sub | cin};
      end else begin : g_merge
         csum_merge #(
            .WIDTH (WIDTH),
            .BLK   (1 << l)
         ) u_merge (
            .i_s0 (g_lvl[l-1].w_q_s0),
            .i_s1 (g_lvl[l-1].w_q_s1),
            .i_c0 (g_lvl[l-1].w_q_c0),
            .i_c1 (g_lvl[l-1].w_q_c1),
            .o_s0 (w_s0),
            .o_s1 (w_s1),
            .o_c0 (w_c0),
            .o_c1 (w_c1)
         );
         assign w_sb = g_lvl[l-1].w_q_sb;
      end

      if (BND && !LAST) begin : g_reg
         // stage boundary: intermediate data register, not reset
         logic [WIDTH-1:0] r_s0, r_s1;
         logic [NB-1:0]    r_c0, r_c1;
         logic [2:0]       r_sb;
         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_s0 <= w_s0;
               r_s1 <= w_s1;
               r_c0 <= w_c0;
               r_c1 <= w_c1;
               r_sb <= w_sb;
            end
         end
         assign w_q_s0 = r_s0;
         assign w_q_s1 = r_s1;
         assign w_q_c0 = r_c0;
         assign w_q_c1 = r_c1;
         assign w_q_sb = r_sb;
      end else begin : g_thru
         assign w_q_s0 = w_s0;
         assign w_q_s1 = w_s1;
         assign w_q_c0 = w_c0;
         assign w_q_c1 = w_c1;
         assign w_q_sb = w_sb;
      end
   end

   // Final select by the effective carry-in, then flag generation.
   assign w_fsb   = g_lvl[LEVELS-1].w_q_sb;
   assign w_fsum  = w_fsb[0] ? g_lvl[LEVELS-1].w_q_s1 : g_lvl[LEVELS-1].w_q_s0;
   assign w_fcout = w_fsb[0] ? g_lvl[LEVELS-1].w_q_c1[0] : g_lvl[LEVELS-1].w_q_c0[0];

   always_comb begin
      w_res                  = '0;
      w_res.sum[WIDTH-1:0]   = w_fsum;
      w_res.cout             = w_fcout;
      w_res.ovf              = (w_fsb[2] == w_fsb[1]) && (w_fsum[WIDTH-1] != w_fsb[2]);
      w_res.zero             = (w_fsum == '0);
   end

   // Output stage: valid chain and result register, both cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_res <= '0;
      end else if (w_adv) begin
         r_vld <= (r_vld << 1) | STAGES'(in_valid);
         r_res <= w_res;
      end
   end

   assign out_valid    = r_vld[STAGES-1];
   assign sum          = r_res.sum[WIDTH-1:0];
   assign cout         = r_res.cout;
   assign ovf          = r_res.ovf;
   assign zero         = r_res.zero;
   // sum bits above WIDTH are always zero
   assign w_unused_res = ^r_res.sum;

endmodule

// File: doc/pipelined_csum_adder.md
PIPELINED_CSUM_ADDER -- requirements
Module: pipelined_csum_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; power of two, 8..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline register stages; 1..log2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned/two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in, add mode only.
REQ-010 SHALL have port op_sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result bits.
REQ-014 SHALL have port cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-015 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port zero  output  1  sum == 0.

Function
REQ-017 Add mode SHALL compute {cout,sum} = a + b + cin; subtract mode SHALL compute a + ~b + 1, ignoring cin.
REQ-018 Datapath SHALL be conditional-sum: level 0 forms per-bit sum0/sum1 pairs; each of log2(WIDTH) merge levels doubles block width, upper half selected by lower half's carry; final select by effective carry-in.
REQ-019 The log2(WIDTH)+1 levels SHALL be split across STAGES register stages, with earlier stages taking the extra level when the split is uneven.
REQ-020 ovf SHALL be 1 iff the sign bits of a and the effective B operand are equal and differ from sum[WIDTH-1].
REQ-021 A beat SHALL transfer in when in_valid & in_ready; out when out_valid & out_ready.
REQ-022 Pipeline advance SHALL be advance = !out_valid | out_ready; in_ready = advance; all stages shift together on advance, hold otherwise.
REQ-023 Per-stage valid bits SHALL propagate with data; a bubble (in_valid=0 on advance) SHALL load valid=0.
REQ-024 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held 1; throughput one beat/cycle.
REQ-025 While out_valid=1 and out_ready=0, sum/cout/ovf/zero SHALL be held stable and no input SHALL be accepted.
REQ-026 Results SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-027 in_ready SHALL depend combinationally only on out_valid and out_ready, not on in_valid.

Reset
REQ-028 rst_n=0 at a clock edge SHALL clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0, zero=0 the following cycle.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-030 Data registers other than outputs need not be reset.

Structure
REQ-031 Package csum_pkg SHALL hold LEVELS = log2(WIDTH)+1, the level-to-stage mapping function, and the result struct {sum, cout, ovf, zero}.
REQ-032 One sub-module csum_merge SHALL implement one merge level (parameter block width, pairwise sum0/sum1 selection), instantiated per level.
REQ-033 Parameter checks SHALL flag illegal WIDTH/STAGES at elaboration.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-034 a=0xFFFF, b=0x0001, cin=0, add -> sum=0x0000, cout=1, ovf=0, zero=1, two cycles later.
REQ-035 a=0x7FFF, b=0x0001, cin=0, add -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-036 a=0x0005, b=0x0007, sub, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-037 Stream 8 random beats, out_ready=0 for 3 cycles mid-stream -> outputs stable during stall, all 8 results correct and in order, in_ready=0 while stalled.
REQ-038 rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, neither beat ever appears.
REQ-039 Sweep WIDTH in {8,32,64} x all legal STAGES with 10k random add/sub beats against reference model -> zero mismatches, latency == STAGES.
